// File: rtl/alu_pkg.sv
// ALU op codes, RV64 opcode constants, the decoded-entry record and the
// skid-buffer state encoding shared by the decode stage.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SLTU = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SRA  = 5'd9,
        ALU_ADDW = 5'd10,
        ALU_SUBW = 5'd11,
        ALU_SLLW = 5'd12,
        ALU_SRLW = 5'd13,
        ALU_SRAW = 5'd14
    } alu_op_e;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] F6_BASE = 6'b000000;
    localparam logic [5:0] F6_ALT  = 6'b010000;

    typedef struct packed {
        logic        illegal;
        alu_op_e     sel;
        logic [63:0] imm;
        logic        use_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
    } dec_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // Sign-extended I-type immediate.
    function automatic logic [63:0] sext_i(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:20]};
    endfunction

    // Base-set op for a funct3 when funct7 selects the non-alternate form.
    function automatic alu_op_e f3_base_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv64_alu_decode_comb.sv
// Combinational RV64 integer-ALU instruction decoder: raw word -> entry.
// Word-size ops (OP-32 / OP-IMM-32) are decoded only when RV64_WORD_OPS_EN
// is defined; otherwise those opcodes decode as illegal.
module rv64_alu_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_entry_t  entry
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign f6     = instr[31:26];

    // Decode fields per opcode, then force the canonical illegal encoding.
    always_comb begin
        logic illegal_c;
        illegal_c     = 1'b0;
        entry         = '0;
        entry.rs1     = instr[19:15];
        entry.rs2     = instr[24:20];
        entry.rd      = instr[11:7];
        entry.we      = 1'b1;
        entry.sel     = ALU_ADD;

        case (opcode)
            OPC_OP: begin
                entry.use_imm = 1'b0;
                if (f7 == F7_BASE) begin
                    entry.sel = f3_base_op(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    entry.sel = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    entry.sel = ALU_SRA;
                end else begin
                    illegal_c = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                entry.use_imm = 1'b1;
                entry.rs2     = 5'd0;
                entry.imm     = sext_i(instr);
                entry.sel     = f3_base_op(f3);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shifts carry a 6-bit shamt, zero-extended.
                    entry.imm = {58'd0, instr[25:20]};
                    if (f6 == F6_ALT && f3 == 3'b101) begin
                        entry.sel = ALU_SRA;
                    end else if (f6 != F6_BASE) begin
                        illegal_c = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                entry.use_imm = 1'b1;
                entry.rs1     = 5'd0;
                entry.rs2     = 5'd0;
                entry.sel     = ALU_ADD;
                entry.imm     = {{32{instr[31]}}, instr[31:12], 12'd0};
            end
`ifdef RV64_WORD_OPS_EN
            OPC_OP_32: begin
                entry.use_imm = 1'b0;
                if (f7 == F7_BASE && f3 == 3'b000)      entry.sel = ALU_ADDW;
                else if (f7 == F7_ALT && f3 == 3'b000)  entry.sel = ALU_SUBW;
                else if (f7 == F7_BASE && f3 == 3'b001) entry.sel = ALU_SLLW;
                else if (f7 == F7_BASE && f3 == 3'b101) entry.sel = ALU_SRLW;
                else if (f7 == F7_ALT && f3 == 3'b101)  entry.sel = ALU_SRAW;
                else                                    illegal_c = 1'b1;
            end
            OPC_OP_IMM_32: begin
                entry.use_imm = 1'b1;
                entry.rs2     = 5'd0;
                // Word shifts take a 5-bit shamt; instr[25] set is rejected
                // by the full funct7 compare below.
                entry.imm     = {59'd0, instr[24:20]};
                if (f3 == 3'b000) begin
                    entry.sel = ALU_ADDW;
                    entry.imm = sext_i(instr);
                end
                else if (f7 == F7_BASE && f3 == 3'b001) entry.sel = ALU_SLLW;
                else if (f7 == F7_BASE && f3 == 3'b101) entry.sel = ALU_SRLW;
                else if (f7 == F7_ALT && f3 == 3'b101)  entry.sel = ALU_SRAW;
                else                                    illegal_c = 1'b1;
            end
`endif
            default: begin
                illegal_c = 1'b1;
            end
        endcase

        if (illegal_c) begin
            entry.illegal = 1'b1;
            entry.sel     = ALU_ADD;
            entry.imm     = 64'd0;
            entry.use_imm = 1'b0;
            entry.we      = 1'b0;
        end
    end

endmodule

// File: rtl/rv64_alu_decode.sv
// Registered RV64 ALU decode stage with a one-entry skid buffer.
// Optional word-op decoding is enabled by defining RV64_WORD_OPS_EN.
module rv64_alu_decode
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_sel,
    output logic [63:0] out_imm,
    output logic        out_use_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    skid_state_e state_reg, state_next;
    dec_entry_t  main_reg, main_next;
    dec_entry_t  skid_reg, skid_next;
    logic        in_ready_reg, in_ready_next;
    dec_entry_t  dec_entry;
    logic        in_fire;
    logic        out_fire;

    rv64_alu_decode_comb u_comb (
        .instr (in_instr),
        .entry (dec_entry)
    );

    assign in_fire  = in_valid && in_ready_reg;
    assign out_fire = (state_reg != ST_EMPTY) && out_ready;

    // Next-state and buffer moves; flush empties both entries.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_next  = dec_entry;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_next = dec_entry;
                end else if (in_fire) begin
                    skid_next  = dec_entry;
                    state_next = ST_TWO;
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_next  = skid_reg;
                    state_next = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_next = ST_EMPTY;
        end
        in_ready_next = (state_next != ST_TWO);
    end

    // State and entry registers; reset clears data and has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            in_ready_reg <= in_ready_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = (state_reg != ST_EMPTY);
    assign out_sel     = main_reg.sel;
    assign out_imm     = main_reg.imm;
    assign out_use_imm = main_reg.use_imm;
    assign out_rs1     = main_reg.rs1;
    assign out_rs2     = main_reg.rs2;
    assign out_rd      = main_reg.rd;
    assign out_we      = main_reg.we;
    assign out_illegal = main_reg.illegal;

endmodule

// File: doc/rv64_alu_decode.md
RV64_ALU_DECODE -- requirements
Module: rv64_alu_decode

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (rising edge), rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  discard all buffered entries at the next edge.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  decoder can accept; registered, skid-buffer empty.
REQ-007 in_instr  input  32  raw RV64 instruction word.
REQ-008 out_valid  output  1  decoded entry present.
REQ-009 out_ready  input  1  downstream (ALU issue) accepts.
REQ-010 out_sel  output  5  ALU op code per alu_pkg.
REQ-011 out_imm  output  64  operand-B immediate.
REQ-012 out_use_imm  output  1  operand B is out_imm, not rs2 data.
REQ-013 out_rs1, out_rs2, out_rd  output  5 each  register indices.
REQ-014 out_we  output  1  result writes rd.
REQ-015 out_illegal  output  1  instruction not decodable by this unit.

Function
REQ-016 SHALL implement a registered decode stage: main register plus one-entry skid register. States EMPTY, ONE (main valid), TWO (main and skid valid).
REQ-017 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-018 Latency one cycle: instruction accepted at edge N is on out_* after edge N, out_valid=1.
REQ-019 EMPTY+in -> ONE; ONE+in+out -> ONE (main replaced); ONE+in, no out -> TWO (entry to skid); ONE+out, no in -> EMPTY; TWO+out -> ONE (skid moves to main); TWO never accepts (in_ready=0).
REQ-020 out_* SHALL hold stable while out_valid && !out_ready; ordering strictly FIFO.
REQ-021 Opcodes: OP 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011, LUI 0110111; all others illegal.
REQ-022 funct3 map: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND; funct7 0100000 selects SUB/SRA, 0000000 the other; any other funct7 on OP illegal.
REQ-023 OP-IMM: funct3 000 is ADD (no SUB); shifts use funct6 000000/010000 with 6-bit shamt, other funct6 illegal.
REQ-024 OP-32/OP-IMM-32 map to ADDW, SUBW (OP-32 only), SLLW, SRLW, SRAW; other funct3 illegal; OP-IMM-32 shift with instr[25]=1 illegal.
REQ-025 I-immediate sign-extended to 64 bits; shift immediates zero-extended shamt; LUI: sel=ADD, rs1=0, imm = sign-extended {instr[31:12],12'b0}.
REQ-026 OP/OP-32: use_imm=0; immediate forms: use_imm=1, rs2=0.
REQ-027 Illegal: out_illegal=1, out_sel=ADD, out_we=0, out_imm=0, use_imm=0; still passes through handshake.
REQ-028 out_we=1 for every legal instruction, including rd=x0.
REQ-029 flush overrides simultaneous in/out transfers: next state EMPTY, in_ready=1.

Reset
REQ-030 On rst: state EMPTY, out_valid=0, in_ready=1, all out_* data fields 0; rst mid-operation discards both entries; rst has priority over flush.

Configuration
REQ-031 Macro RV64_WORD_OPS_EN: defined -> REQ-024 decoding active; undefined -> OP-32 and OP-IMM-32 decode as illegal and ADDW..SRAW codes are never emitted.

Structure
REQ-032 alu_pkg SHALL hold ALU op codes ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, ADDW=10, SUBW=11, SLLW=12, SRLW=13, SRAW=14, opcode constants and the decoded-entry struct.
REQ-033 Combinational decode SHALL be sub-module rv64_alu_decode_comb (instr -> entry struct); the top holds only skid/handshake logic.

Verification
REQ-034 0xFFF00093 (ADDI x1,x0,-1) -> sel 0, imm 0xFFFFFFFFFFFFFFFF, use_imm 1, rd 1, illegal 0.
REQ-035 0x402081B3 (SUB x3,x1,x2) -> sel 1, use_imm 0, rs1 1, rs2 2, rd 3.
REQ-036 0x4200D09B (SRAIW, instr[25]=1) -> illegal 1, we 0; without RV64_WORD_OPS_EN any 0x3B/0x1B opcode -> illegal 1.
REQ-037 Stream of 4 instructions, out_ready=0 for 3 cycles -> in_ready falls after 2 accepted, no loss, outputs stable, all 4 emitted in order.
REQ-038 State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted; rst in TWO -> same plus data fields 0.
